// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - Byte-wide RAM responder with a memory-mapped FIFO/LED/button/counter window
// The top 8 byte addresses shadow RAM with I/O registers; all reads are registered (1-cycle latency).
module mem_responder #(
   parameter int ADDR_WIDTH = 9,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [ADDR_WIDTH-1:0] i_mem_raddr,
   input  logic [ADDR_WIDTH-1:0] i_mem_waddr,
   input  logic                  i_mem_write,
   input  logic [7:0]            i_mem_data_in,
   output logic [7:0]            o_mem_data_out,
   output logic                  o_mem_ready,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_rx_ready,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic [7:0]            o_leds,
   input  logic [2:0]            i_buttons
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int RAM_BYTES = 2**ADDR_WIDTH;
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

   logic [7:0]    r_ram    [0:RAM_BYTES-1];
   logic [7:0]    r_tx_mem [0:FIFO_DEPTH-1];
   logic [7:0]    r_rx_mem [0:FIFO_DEPTH-1];
   logic [PW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
   logic [PW:0]   r_tx_count, r_rx_count;
   logic          r_ovf, r_ready;
   logic [7:0]    r_leds, r_data_out;
   logic [2:0]    r_btn_meta, r_btn_sync;
   logic [31:0]   r_counter, r_snapshot;

   logic       w_rd_io, w_wr_io, w_wr_cmd;
   logic [2:0] w_roff, w_woff;
   logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic       w_tx_push, w_tx_pop, w_tx_accept, w_rx_push, w_rx_pop, w_flush;
   logic [7:0] w_status, w_io_rdata;

   assign w_rd_io  = &i_mem_raddr[ADDR_WIDTH-1:3];
   assign w_wr_io  = &i_mem_waddr[ADDR_WIDTH-1:3];
   assign w_roff   = i_mem_raddr[2:0];
   assign w_woff   = i_mem_waddr[2:0];
   assign w_wr_cmd = i_mem_write & w_wr_io;

   assign w_tx_full  = (r_tx_count == FULL_COUNT);
   assign w_tx_empty = (r_tx_count == '0);
   assign w_rx_full  = (r_rx_count == FULL_COUNT);
   assign w_rx_empty = (r_rx_count == '0);

   // A push into a full TX FIFO still lands if the head leaves in the same cycle.
   assign w_tx_pop    = ~w_tx_empty & i_tx_ready;
   assign w_tx_push   = w_wr_cmd & (w_woff == 3'd0);
   assign w_tx_accept = w_tx_push & (~w_tx_full | w_tx_pop);
   assign w_flush     = w_wr_cmd & (w_woff == 3'd1) & i_mem_data_in[1];
   assign w_rx_pop    = w_wr_cmd & (w_woff == 3'd1) & i_mem_data_in[0] & ~w_rx_empty;
   assign w_rx_push   = i_rx_valid & o_rx_ready;

   assign o_rx_ready     = r_ready & ~w_rx_full;
   assign o_tx_valid     = ~w_tx_empty;
   assign o_tx_data      = r_tx_mem[r_tx_rptr];
   assign o_mem_ready    = r_ready;
   assign o_leds         = r_leds;
   assign o_mem_data_out = r_data_out;
   assign w_status       = {3'b000, r_ovf, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};

   always_comb begin
      w_io_rdata = 8'h00;
      case (w_roff)
         3'd0:    w_io_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
         3'd1:    w_io_rdata = w_status;
         3'd2:    w_io_rdata = r_leds;
         3'd3:    w_io_rdata = {5'b00000, r_btn_sync};
         3'd4:    w_io_rdata = r_snapshot[31:24];
         3'd5:    w_io_rdata = r_snapshot[23:16];
         3'd6:    w_io_rdata = r_snapshot[15:8];
         default: w_io_rdata = r_snapshot[7:0];
      endcase
   end

   // Storage arrays carry no reset so they map onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_mem_write && !w_wr_io)
         r_ram[i_mem_waddr] <= i_mem_data_in;
      if (w_tx_accept)
         r_tx_mem[r_tx_wptr] <= i_mem_data_in;
      if (w_rx_push)
         r_rx_mem[r_rx_wptr] <= i_rx_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_data_out <= 8'h00;
      else
         r_data_out <= w_rd_io ? w_io_rdata : r_ram[i_mem_raddr];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ready    <= 1'b0;
         r_counter  <= '0;
         r_snapshot <= '0;
         r_leds     <= '0;
         r_btn_meta <= '0;
         r_btn_sync <= '0;
         r_ovf      <= 1'b0;
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_count <= '0;
         r_rx_wptr  <= '0;
         r_rx_rptr  <= '0;
         r_rx_count <= '0;
      end else begin
         r_ready    <= 1'b1;
         r_counter  <= r_counter + 32'd1;
         r_btn_meta <= i_buttons;
         r_btn_sync <= r_btn_meta;
         if (w_wr_cmd && w_woff == 3'd2)
            r_leds <= i_mem_data_in;
         if (w_wr_cmd && w_woff == 3'd4)
            r_snapshot <= r_counter;
         if (w_flush) begin
            r_ovf      <= 1'b0;
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
         end else begin
            if (w_tx_push && w_tx_full && !w_tx_pop)
               r_ovf <= 1'b1;
            if (w_tx_accept)
               r_tx_wptr <= r_tx_wptr + PW'(1);
            if (w_tx_pop)
               r_tx_rptr <= r_tx_rptr + PW'(1);
            r_tx_count <= r_tx_count + (PW+1)'(w_tx_accept) - (PW+1)'(w_tx_pop);
            if (w_rx_push)
               r_rx_wptr <= r_rx_wptr + PW'(1);
            if (w_rx_pop)
               r_rx_rptr <= r_rx_rptr + PW'(1);
            r_rx_count <= r_rx_count + (PW+1)'(w_rx_push) - (PW+1)'(w_rx_pop);
         end
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - Randomized bench for mem_responder against a queue-based reference model
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_mem_responder;
   localparam int AW    = 9;
   localparam int DEPTH = 16;
   localparam int BASE  = 2**AW - 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] mem_raddr = '0;
   logic [AW-1:0] mem_waddr = '0;
   logic          mem_write = 1'b0;
   logic [7:0]    mem_data_in = '0;
   logic [7:0]    mem_data_out;
   logic          mem_ready;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic [7:0]    leds;
   logic [2:0]    buttons = '0;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_mem_raddr(mem_raddr), .i_mem_waddr(mem_waddr), .i_mem_write(mem_write),
      .i_mem_data_in(mem_data_in), .o_mem_data_out(mem_data_out), .o_mem_ready(mem_ready),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
      .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .o_leds(leds), .i_buttons(buttons)
   );

   logic [7:0]  m_ram [0:BASE-1];
   logic [7:0]  m_tx[$];
   logic [7:0]  m_rx[$];
   bit          m_ovf, m_ready;
   logic [7:0]  m_leds;
   logic [2:0]  m_b1, m_b2;
   logic [31:0] m_counter, m_snap;
   int          checks = 0;
   int          failures = 0;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [AW-1:0] a);
      int off;
      if (int'(a) < BASE) return m_ram[a];
      off = int'(a) - BASE;
      case (off)
         0: return (m_rx.size() > 0) ? m_rx[0] : 8'h00;
         1: return 8'((m_ovf ? 16 : 0) + (m_tx.size() == DEPTH ? 8 : 0) + (m_tx.size() == 0 ? 4 : 0)
                     + (m_rx.size() == DEPTH ? 2 : 0) + (m_rx.size() == 0 ? 1 : 0));
         2: return m_leds;
         3: return {5'b00000, m_b2};
         default: return 8'(m_snap >> (8 * (7 - off)));
      endcase
   endfunction

   // One clock: update the model from the current inputs, take the edge, then check outputs.
   task automatic step();
      int         off;
      bit         tx_pop, rx_push, wr_io;
      logic [7:0] exp_out;
      if (reset) begin
         exp_out = 8'h00;
         m_tx.delete(); m_rx.delete();
         m_ovf = 0; m_ready = 0; m_leds = 0; m_b1 = 0; m_b2 = 0; m_counter = 0; m_snap = 0;
      end else begin
         exp_out = model_read(mem_raddr);
         tx_pop  = (m_tx.size() > 0) && tx_ready;
         rx_push = rx_valid && m_ready && (m_rx.size() < DEPTH);
         wr_io   = mem_write && (int'(mem_waddr) >= BASE);
         off     = wr_io ? int'(mem_waddr) - BASE : -1;
         if (mem_write && !wr_io) m_ram[mem_waddr] = mem_data_in;
         if (off == 2) m_leds = mem_data_in;
         if (off == 4) m_snap = m_counter;
         if (off == 1 && mem_data_in[1]) begin
            m_tx.delete(); m_rx.delete(); m_ovf = 0;
         end else begin
            if (tx_pop) void'(m_tx.pop_front());
            if (off == 0) begin
               if (m_tx.size() < DEPTH) m_tx.push_back(mem_data_in);
               else m_ovf = 1;
            end
            if (off == 1 && mem_data_in[0] && m_rx.size() > 0) void'(m_rx.pop_front());
            if (rx_push) m_rx.push_back(rx_data);
         end
         m_b2 = m_b1; m_b1 = buttons;
         m_counter = m_counter + 32'd1;
         m_ready = 1;
      end
      @(posedge clk);
      #1;
      expect_eq("rdata", mem_data_out, exp_out);
      expect_eq("mem_ready", mem_ready, m_ready);
      expect_eq("rx_ready", rx_ready, m_ready && (m_rx.size() < DEPTH));
      expect_eq("tx_valid", tx_valid, m_tx.size() != 0);
      if (m_tx.size() != 0) expect_eq("tx_data", tx_data, m_tx[0]);
      expect_eq("leds", leds, m_leds);
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      mem_write = 1'b1; mem_waddr = AW'(a); mem_data_in = d;
      step();
      mem_write = 1'b0;
   endtask

   task automatic rd(input int a);
      mem_raddr = AW'(a);
      step();
   endtask

   task automatic random_cycle(input int tx_pct, input int rx_pct);
      int r;
      reset     = ($urandom_range(0, 299) == 0);
      tx_ready  = ($urandom_range(0, 99) < tx_pct);
      rx_valid  = ($urandom_range(0, 99) < rx_pct);
      rx_data   = 8'($urandom);
      buttons   = 3'($urandom);
      mem_raddr = $urandom_range(0, 1) ? AW'(BASE + $urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      mem_write = !reset && ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 1) == 1) begin
         r = $urandom_range(0, 9);
         mem_waddr = AW'(BASE + ((r < 5) ? 0 : (r < 7) ? 1 : $urandom_range(2, 7)));
         if (int'(mem_waddr) == BASE + 1)
            mem_data_in = ($urandom_range(0, 19) == 0) ? 8'h02 : 8'($urandom_range(0, 1));
         else
            mem_data_in = 8'($urandom);
      end else begin
         mem_waddr   = AW'($urandom_range(0, 31));
         mem_data_in = 8'($urandom);
      end
      step();
   endtask

   initial begin
      mem_raddr = AW'(BASE + 1);
      step(); step();
      reset = 1'b0;
      for (int a = 0; a < BASE; a++) wr(a, 8'($urandom));

      // RAM write/read and read-before-write on a shared address
      wr(16, 8'hA5);
      rd(16);
      expect_eq("ram_read", mem_data_out, 8'hA5);
      mem_write = 1'b1; mem_waddr = AW'(16); mem_data_in = 8'h3C;
      step();
      mem_write = 1'b0;
      expect_eq("ram_old_value", mem_data_out, 8'hA5);
      step();
      expect_eq("ram_new_value", mem_data_out, 8'h3C);

      // TX delivery
      tx_ready = 1'b0;
      wr(BASE, 8'h41); wr(BASE, 8'h42);
      expect_eq("tx_head_first", tx_data, 8'h41);
      tx_ready = 1'b1;
      step();
      expect_eq("tx_head_second", tx_data, 8'h42);
      step();
      expect_eq("tx_drained", tx_valid, 1'b0);
      tx_ready = 1'b0;
      rd(BASE + 1);
      expect_eq("status_idle", mem_data_out, 8'h05);

      // TX overflow, flush, and push-with-pop while full
      for (int i = 0; i < 17; i++) wr(BASE, 8'(8'h60 + i));
      rd(BASE + 1);
      expect_eq("status_ovf_full", mem_data_out, 8'h19);
      wr(BASE + 1, 8'h02);
      rd(BASE + 1);
      expect_eq("status_flushed", mem_data_out, 8'h05);
      for (int i = 0; i < 16; i++) wr(BASE, 8'(8'h80 + i));
      tx_ready = 1'b1;
      wr(BASE, 8'hEE);
      tx_ready = 1'b0;
      rd(BASE + 1);
      expect_eq("status_full_no_ovf", mem_data_out, 8'h09);
      wr(BASE + 1, 8'h02);

      // RX fill, pop while full, push and pop together
      for (int i = 0; i < 16; i++) begin
         rx_valid = 1'b1; rx_data = 8'(8'h10 + i);
         step();
      end
      rx_valid = 1'b0;
      expect_eq("rx_full_ready", rx_ready, 1'b0);
      rd(BASE);
      expect_eq("rx_head", mem_data_out, 8'h10);
      rx_valid = 1'b1; rx_data = 8'h55;
      wr(BASE + 1, 8'h01);
      rx_valid = 1'b0;
      rd(BASE);
      expect_eq("rx_head_after_pop", mem_data_out, 8'h11);
      rx_valid = 1'b1; rx_data = 8'h66;
      wr(BASE + 1, 8'h01);
      rx_valid = 1'b0;
      rd(BASE);
      expect_eq("rx_head_push_pop", mem_data_out, 8'h12);
      wr(BASE + 1, 8'h02);

      // Buttons through the synchroniser
      buttons = 3'b101;
      step(); step();
      rd(BASE + 3);
      expect_eq("buttons", mem_data_out, 8'h05);

      // Counter snapshot
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 1000 && m_counter != 32'h1F3; i++) step();
      expect_eq("counter_reached", m_counter, 32'h1F3);
      wr(BASE + 4, 8'h77);
      rd(BASE + 4); expect_eq("snap_b3", mem_data_out, 8'h00);
      rd(BASE + 5); expect_eq("snap_b2", mem_data_out, 8'h00);
      rd(BASE + 6); expect_eq("snap_b1", mem_data_out, 8'h01);
      rd(BASE + 7); expect_eq("snap_b0", mem_data_out, 8'hF3);
      for (int i = 0; i < 20; i++) step();
      rd(BASE + 7); expect_eq("snap_held", mem_data_out, 8'hF3);

      // LEDs and reset
      wr(BASE + 2, 8'h81);
      expect_eq("leds_set", leds, 8'h81);
      reset = 1'b1; step();
      expect_eq("leds_reset", leds, 8'h00);
      expect_eq("ready_in_reset", mem_ready, 1'b0);
      reset = 1'b0; step();
      expect_eq("ready_after_reset", mem_ready, 1'b1);

      // Randomized traffic with varying producer/consumer rates
      for (int seg = 0; seg < 8; seg++) begin
         int tp, rp;
         tp = (seg % 3 == 0) ? 10 : (seg % 3 == 1) ? 50 : 90;
         rp = (seg % 2 == 0) ? 80 : 20;
         for (int i = 0; i < 400; i++) random_cycle(tp, rp);
      end
      reset = 1'b0; mem_write = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
